// File: rtl/bram_reader_pkg.sv
// rtl/bram_reader_pkg.sv - shared FSM type and pipeline/FIFO sizing for bram_stream_reader
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam int BRAM_RD_LATENCY = 2;
  localparam int OUT_FIFO_DEPTH  = BRAM_RD_LATENCY + 2;

endpackage

// File: rtl/bram_reader_fifo.sv
// rtl/bram_reader_fifo.sv - small synchronous FIFO with occupancy count for the reader output stage
module bram_reader_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (i_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!i_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // The reader's credit scheme is what keeps this from overflowing.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - streams LEN BRAM words from a base address as an AXI-Stream packet
// Optional BRAM_READER_PERF_EN adds the stall_cnt backpressure counter output.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 2048,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  done
`ifdef BRAM_READER_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int CW = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_ready_en;
  logic [ADDR_WIDTH-1:0]      r_cur;
  logic [LEN_WIDTH-1:0]       r_remaining;
  logic [BRAM_RD_LATENCY-1:0] r_pipe;
  logic [BRAM_RD_LATENCY-1:0] r_pipe_last;
  logic                       r_done;

  logic                       w_start_hs;
  logic                       w_issue;
  logic                       w_pop;
  logic                       w_last_pop;
  logic [2:0]                 w_inflight;
  logic [3:0]                 w_occ;
  logic [DATA_WIDTH:0]        w_fifo_rdata;
  logic                       w_fifo_empty;
  logic [CW-1:0]              w_fifo_count;

  assign start_ready = r_ready_en && (r_state == IDLE);
  assign w_start_hs  = start_valid && start_ready;
  assign w_pop       = m_axis_tvalid && m_axis_tready;
  assign w_last_pop  = w_pop && w_fifo_rdata[DATA_WIDTH];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < BRAM_RD_LATENCY; i++) begin
      w_inflight = w_inflight + 3'(r_pipe[i]);
    end
  end

  // Every read in flight owns a FIFO slot, so the FIFO can absorb a full stall.
  assign w_occ   = 4'(w_inflight) + 4'(w_fifo_count);
  assign w_issue = (r_state == READ) && (r_remaining != '0) && (w_occ < 4'(OUT_FIFO_DEPTH));

  assign bram_en   = w_issue;
  assign bram_addr = r_cur;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start_hs && (start_len != '0)) w_state_next = READ;
      READ:    if (w_issue && (r_remaining == LEN_WIDTH'(1))) w_state_next = DRAIN;
      DRAIN:   if (w_last_pop) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ready_en  <= 1'b0;
      r_cur       <= '0;
      r_remaining <= '0;
      r_pipe      <= '0;
      r_pipe_last <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ready_en  <= 1'b1;
      r_done      <= (w_start_hs && (start_len == '0)) || w_last_pop;
      r_pipe      <= {r_pipe[BRAM_RD_LATENCY-2:0], w_issue};
      r_pipe_last <= {r_pipe_last[BRAM_RD_LATENCY-2:0],
                      w_issue && (r_remaining == LEN_WIDTH'(1))};
      if (w_start_hs) begin
        r_cur       <= start_addr;
        r_remaining <= start_len;
      end else if (w_issue) begin
        r_cur       <= (r_cur == LAST_ADDR) ? '0 : r_cur + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
    end
  end

  bram_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_pipe[BRAM_RD_LATENCY-1]),
    .i_wdata ({r_pipe_last[BRAM_RD_LATENCY-1], bram_dout}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign m_axis_tvalid = !w_fifo_empty;
  assign m_axis_tdata  = w_fifo_empty ? '0 : w_fifo_rdata[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !w_fifo_empty && w_fifo_rdata[DATA_WIDTH];
  assign done          = r_done;

`ifdef BRAM_READER_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_hs) begin
      r_stall_cnt <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - self-checking bench for bram_stream_reader against a 2-cycle BRAM model
`timescale 1ns/1ps
module tb_bram_stream_reader;

  localparam int DW    = 64;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int LW    = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] start_len = '0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          done;
`ifdef BRAM_READER_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  bram_stream_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .start_addr    (start_addr),
    .start_len     (start_len),
    .bram_en       (bram_en),
    .bram_addr     (bram_addr),
    .bram_dout     (bram_dout),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .done          (done)
`ifdef BRAM_READER_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // Port-B read model: registered address stage plus output register.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] r_b1, r_b2;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA000_0000_0000_0000 + 64'(i);
  always @(posedge clk) begin
    if (bram_en) r_b1 <= mem[bram_addr];
    r_b2 <= r_b1;
  end
  assign bram_dout = r_b2;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [AW-1:0] q_addr[$];
  logic [DW:0]   q_beat[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int issued, popped, hs_cnt, done_cnt, done_cyc, last_cyc, first_cyc;
  bit first_seen, done_rdy, prev_stall;
  logic [DW-1:0] prev_data;
  logic prev_last;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid_held", 64'(m_axis_tvalid), 64'd1);
        chk("stall_tdata_stable", m_axis_tdata, prev_data);
        chk("stall_tlast_stable", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (bram_en) begin
        issued++;
        if (q_addr.size() == 0) chk("bram_en_unexpected", 64'(bram_en), 64'd0);
        else chk("bram_addr", 64'(bram_addr), 64'(q_addr.pop_front()));
      end
      chk("occupancy_le4", 64'((issued - popped) <= 4), 64'd1);
      if (m_axis_tvalid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        popped++;
        hs_cnt++;
        if (q_beat.size() == 0) begin
          chk("tvalid_unexpected", 64'(m_axis_tvalid), 64'd0);
        end else begin
          e = q_beat.pop_front();
          chk("tdata", m_axis_tdata, e[DW-1:0]);
          chk("tlast", 64'(m_axis_tlast), 64'(e[DW]));
          if (m_axis_tlast) last_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_rdy = start_ready;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  int rdy_pct = 100;
  bit rdy_hold_lo = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_hold_lo) m_axis_tready = 1'b0;
      else if (rdy_pct >= 100) m_axis_tready = 1'b1;
      else m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, 64'(start_ready), 64'd0);
    chk({tag, "_bram_en"}, 64'(bram_en), 64'd0);
    chk({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, "_tdata"}, m_axis_tdata, 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic start_cmd(input int addr, input int len, output int hs_cyc);
    int guard = 0;
    int a;
    @(posedge clk); #1;
    while (!start_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("start_ready_before_cmd", 64'(start_ready), 64'd1);
    for (int i = 0; i < len; i++) begin
      a = (addr + i) % DEPTH;
      q_addr.push_back(AW'(a));
      q_beat.push_back({i == len - 1, 64'hA000_0000_0000_0000 + 64'(a)});
    end
    first_seen = 1'b0;
    done_cnt = 0;
    hs_cnt = 0;
    start_valid = 1'b1;
    start_addr = AW'(addr);
    start_len = LW'(len);
    hs_cyc = cyc;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!(done_cnt > 0 && q_beat.size() == 0 && q_addr.size() == 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("packet_complete_in_time", 64'(guard < 5000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_cmd(input int len, input int hs, input int exp_lat);
    chk("done_pulse_count", 64'(done_cnt), 64'd1);
    chk("beat_count", 64'(hs_cnt), 64'(len));
    chk("start_ready_with_done", 64'(done_rdy), 64'd1);
    if (len == 0) begin
      chk("len0_done_cycle", 64'(done_cyc), 64'(hs + 1));
      chk("len0_no_tvalid", 64'(first_seen), 64'd0);
    end else begin
      chk("done_after_last_beat", 64'(done_cyc), 64'(last_cyc + 1));
    end
    if (exp_lat >= 0) chk("first_tvalid_latency", 64'(first_cyc - hs), 64'(exp_lat));
  endtask

  typedef struct {
    int addr;
    int len;
    int pct;
    int exp_beats;
    int exp_lat;
  } vec_t;

  vec_t vecs[7];
  int   hs;

  initial begin
    vecs[0] = '{addr: 10,   len: 8,    pct: 100, exp_beats: 8,    exp_lat: 4};
    vecs[1] = '{addr: 2044, len: 6,    pct: 100, exp_beats: 6,    exp_lat: 4};
    vecs[2] = '{addr: 100,  len: 16,   pct: 50,  exp_beats: 16,   exp_lat: -1};
    vecs[3] = '{addr: 77,   len: 0,    pct: 100, exp_beats: 0,    exp_lat: -1};
    vecs[4] = '{addr: 2047, len: 1,    pct: 100, exp_beats: 1,    exp_lat: 4};
    vecs[5] = '{addr: 300,  len: 20,   pct: 30,  exp_beats: 20,   exp_lat: -1};
    vecs[6] = '{addr: 1000, len: 2048, pct: 100, exp_beats: 2048, exp_lat: 4};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_ready_after_reset", 64'(start_ready), 64'd1);

    for (int v = 0; v < 7; v++) begin
      rdy_pct = vecs[v].pct;
      start_cmd(vecs[v].addr, vecs[v].len, hs);
      wait_done();
      check_cmd(vecs[v].exp_beats, hs, vecs[v].exp_lat);
    end

    // Reset in the middle of a 10-beat packet, then a fresh 2-beat command.
    begin
      int guard = 0;
      rdy_pct = 100;
      start_cmd(0, 10, hs);
      while (hs_cnt < 3 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      q_addr.delete();
      q_beat.delete();
      issued = 0;
      popped = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_cmd(0, 2, hs);
      wait_done();
      check_cmd(2, hs, 4);
    end

`ifdef BRAM_READER_PERF_EN
    begin
      int guard = 0;
      rdy_hold_lo = 1'b1;
      start_cmd(40, 4, hs);
      @(negedge clk);
      while (!m_axis_tvalid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      repeat (4) @(negedge clk);
      rdy_hold_lo = 1'b0;
      wait_done();
      check_cmd(4, hs, -1);
      chk("stall_cnt", 64'(stall_cnt), 64'd5);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
